// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

  localparam logic [1:0] MODE_ARITH   = 2'd0;
  localparam logic [1:0] MODE_LOGIC   = 2'd1;
  localparam logic [1:0] MODE_COMPARE = 2'd2;
  localparam logic [1:0] MODE_MAGIC   = 2'd3;

  localparam int ABORT_BIT = 9;

  function automatic logic [9:0] pack_alu_in(input logic [3:0] opb, input logic [3:0] opa);
    return {2'b00, opb, opa};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, one-cycle pulse on accepted press.
// A press is only armed once a released level has been seen after reset.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          armed;
  logic [1:0]    fill;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      armed  <= 1'b0;
      fill   <= 2'b00;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      press <= 1'b0;
      // fill[1] marks the synchronizer as holding real samples, so a button
      // held through reset can never arm the pulse.
      if (fill[1] && stable && sync2)
        armed <= 1'b1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= sync2;
        press  <= armed && !sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps through operand A, operand B and mode/function entry on button presses,
// holds them at the ALU for SETTLE_CYCLES, then registers the ALU result.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic       MAX10_CLK1_50,
  input  logic       rst,
  input  logic       key_n,
  input  logic [9:0] SW,
  input  logic [9:0] alu_result,
  output logic [9:0] alu_in,
  output logic [1:0] alu_a,
  output logic [1:0] alu_b,
  output logic [9:0] result,
  output logic       done,
  output logic [2:0] phase
);

  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);

  seq_state_t      state;
  logic [3:0]      opa;
  logic [3:0]      opb;
  logic [ST_W-1:0] settle;
  logic            press;
  logic            abort;
  logic            unused_sw;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk   (MAX10_CLK1_50),
    .rst   (rst),
    .key_n (key_n),
    .press (press)
  );

  assign abort     = SW[ABORT_BIT];
  assign unused_sw = ^SW[8:4];

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      state  <= LOAD_A;
      opa    <= '0;
      opb    <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      result <= '0;
      done   <= 1'b0;
      settle <= '0;
    end else begin
      case (state)
        LOAD_A: if (press) begin
          if (abort) state <= LOAD_A;
          else begin
            opa   <= SW[3:0];
            state <= LOAD_B;
          end
        end
        LOAD_B: if (press) begin
          if (abort) state <= LOAD_A;
          else begin
            opb   <= SW[3:0];
            state <= LOAD_OP;
          end
        end
        LOAD_OP: if (press) begin
          if (abort) state <= LOAD_A;
          else begin
            alu_a  <= SW[3:2];
            alu_b  <= SW[1:0];
            settle <= '0;
            state  <= EXEC;
          end
        end
        // Presses here are dropped, including one on the terminal edge.
        EXEC: begin
          if (settle == SETTLE_LAST) begin
            result <= alu_result;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        DONE: if (press) begin
          done  <= 1'b0;
          state <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign alu_in = pack_alu_in(opb, opa);
  assign phase  = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench: operation table with result scoreboard, plus debounce/abort/EXEC/reset sequences.
module tb_alu_operand_sequencer;

  localparam int DEB  = 4;
  localparam int SETL = 2;
  localparam int HOLD = DEB + 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_n = 1'b1;
  logic [9:0] sw = '0;
  logic [9:0] alu_result;
  logic [9:0] alu_in;
  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [9:0] result;
  logic       done;
  logic [2:0] phase;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SETL)) dut (
    .MAX10_CLK1_50 (clk),
    .rst           (rst),
    .key_n         (key_n),
    .SW            (sw),
    .alu_result    (alu_result),
    .alu_in        (alu_in),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .result        (result),
    .done          (done),
    .phase         (phase)
  );

  always #5 clk = ~clk;

  // Reference ALU: opa in alu_in[3:0], opb in alu_in[7:4].
  function automatic logic [9:0] alu_model(input logic [9:0] in, input logic [1:0] m, input logic [1:0] f);
    logic [3:0] a;
    logic [3:0] b;
    logic [9:0] r;
    a = in[3:0];
    b = in[7:4];
    r = '0;
    case (m)
      2'd0: case (f)
        2'd0: r = 10'(a) + 10'(b);
        2'd1: r = 10'(a) - 10'(b);
        2'd2: r = 10'(a) * 10'(b);
        default: r = 10'(a) + 10'd1;
      endcase
      2'd1: case (f)
        2'd0: r = {6'b0, a & b};
        2'd1: r = {6'b0, a | b};
        2'd2: r = {6'b0, a ^ b};
        default: r = {6'b0, ~a};
      endcase
      2'd2: case (f)
        2'd0: r = {9'b0, a == b};
        2'd1: r = {9'b0, a < b};
        2'd2: r = {9'b0, a > b};
        default: r = (a > b) ? 10'(a) : 10'(b);
      endcase
      default: r = {2'b10, a, b};
    endcase
    return r;
  endfunction

  always_comb alu_result = alu_model(alu_in, alu_a, alu_b);

  typedef struct {
    logic [9:0] sw_a;
    logic [9:0] sw_b;
    logic [9:0] sw_op;
    logic [9:0] exp_in;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    logic [9:0] exp_res;
  } vec_t;

  typedef struct {
    logic [9:0] in;
    logic [1:0] a;
    logic [1:0] b;
    logic [9:0] res;
  } exp_t;

  vec_t       vecs[5];
  exp_t       sb[$];
  logic [2:0] phase_log[$];
  logic [2:0] last_phase = 3'd0;
  logic       done_q = 1'b0;
  int         exec_cnt = 0;
  int         exec_len = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Phase change log and EXEC dwell measurement.
  always @(negedge clk) begin
    if (phase == 3'd3) exec_cnt++;
    else if (phase != 3'd4) exec_cnt = 0;
    if (done && !done_q) exec_len = exec_cnt;
    done_q = done;
    if (phase !== last_phase) begin
      phase_log.push_back(phase);
      last_phase = phase;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press_btn(input logic [9:0] v);
    @(posedge clk); #1;
    sw = v;
    key_n = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1;
  endtask

  task automatic wait_done_and_check();
    exp_t e;
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    #1;
    chk("done_wait", done, 1);
    chk("sb_nonempty", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("alu_in", alu_in, e.in);
      chk("alu_a", alu_a, e.a);
      chk("alu_b", alu_b, e.b);
      chk("result", result, e.res);
      chk("exec_len", exec_len, SETL);
    end
  endtask

  task automatic wait_exec();
    for (int i = 0; i < 30 && phase != 3'd3; i++) @(negedge clk);
    chk("reach_exec", phase, 3);
  endtask

  initial begin
    int n;
    exp_t e;
    vecs[0] = '{10'h005, 10'h003, 10'h000, 10'h035, 2'd0, 2'd0, 10'h008};
    vecs[1] = '{10'h1FC, 10'h00A, 10'h005, 10'h0AC, 2'd1, 2'd1, 10'h00E};
    vecs[2] = '{10'h009, 10'h004, 10'h00A, 10'h049, 2'd2, 2'd2, 10'h001};
    vecs[3] = '{10'h00F, 10'h00F, 10'h00F, 10'h0FF, 2'd3, 2'd3, 10'h2FF};
    vecs[4] = '{10'h003, 10'h005, 10'h001, 10'h053, 2'd0, 2'd1, 10'h3FE};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_alu_in", alu_in, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);

    @(posedge clk); #1;
    phase_log.delete();
    last_phase = phase;

    for (int i = 0; i < 5; i++) begin
      sb.push_back('{vecs[i].exp_in, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_res});
      press_btn(vecs[i].sw_a);
      press_btn(vecs[i].sw_b);
      press_btn(vecs[i].sw_op);
      wait_done_and_check();
      if (i == 0) begin
        chk("phase_log_len", phase_log.size(), 4);
        for (int k = 0; k < 4 && k < phase_log.size(); k++)
          chk("phase_seq", phase_log[k], k + 1);
      end
      // SW[9] set on purpose: it must not matter in DONE.
      press_btn(10'h200);
      chk("ret_done", done, 0);
      chk("ret_phase", phase, 0);
      chk("ret_result", result, vecs[i].exp_res);
    end

    // Abort from LOAD_OP keeps already-captured registers.
    press_btn(10'h00A);
    press_btn(10'h00C);
    press_btn(10'h200);
    chk("abort_phase", phase, 0);
    chk("abort_alu_in", alu_in, 10'h0CA);
    chk("abort_alu_a", alu_a, 2'd0);
    chk("abort_alu_b", alu_b, 2'd1);

    // Bouncing button: only the final settled fall counts.
    @(posedge clk); #1;
    sw = 10'h007;
    for (int i = 0; i < 10; i++) begin
      key_n = ~key_n;
      repeat (2) @(posedge clk);
      #1;
    end
    key_n = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (phase != 3'd0) begin
        n = i;
        break;
      end
    end
    chk("bounce_latency_ok", (n >= 6 && n <= 8), 1);
    repeat (20) @(negedge clk);
    chk("bounce_one_step", phase, 1);
    @(posedge clk); #1 key_n = 1'b1;
    repeat (HOLD) @(posedge clk);

    // Press injected inside EXEC must be dropped.
    press_btn(10'h002);
    sw = 10'h006;
    key_n = 1'b0;
    wait_exec();
    force dut.press = 1'b1;
    @(posedge clk); #1;
    release dut.press;
    sb.push_back('{10'h027, 2'd1, 2'd2, 10'h005});
    wait_done_and_check();
    repeat (10) @(negedge clk);
    chk("exec_press_phase", phase, 4);
    chk("exec_press_done", done, 1);
    @(posedge clk); #1 key_n = 1'b1;
    repeat (HOLD) @(posedge clk);
    chk("release_no_press", phase, 4);
    press_btn(10'h000);
    chk("exec_ret_phase", phase, 0);

    // Reset mid-EXEC with button held through reset.
    press_btn(10'h001);
    press_btn(10'h002);
    @(posedge clk); #1;
    sw = 10'h00F;
    key_n = 1'b0;
    wait_exec();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    phase_log.delete();
    last_phase = phase;
    @(negedge clk);
    chk("mid_rst_phase", phase, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_alu_in", alu_in, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    repeat (20) @(negedge clk);
    chk("held_no_press", phase_log.size(), 0);
    @(posedge clk); #1 key_n = 1'b1;
    repeat (HOLD) @(posedge clk);
    chk("release_no_press2", phase, 0);
    press_btn(10'h003);
    chk("repress_phase", phase, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
